// File: rtl/ldpc_rd_addr_gen.sv
// LDPC read-address sequencer: for one base-matrix row, walks circulant rows
// 0..Z-1 and, per row, emits base + ((offset_k + row) mod Z) for every
// enabled offset slot k, lowest slot first, under a valid/ready handshake.
module ldpc_rd_addr_gen #(
    parameter int A_WID = 8,
    parameter int N_OFF = 3,
    parameter int I_WID = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [A_WID-1:0]       base_addr,
    input  logic [N_OFF*A_WID-1:0] addr_offset,
    input  logic [N_OFF-1:0]       off_en,
    input  logic [A_WID-1:0]       z_size,
    input  logic                   rd_rdy,
    output logic [A_WID-1:0]       rd_addr,
    output logic                   rd_vld,
    output logic [I_WID-1:0]       rd_idx,
    output logic [A_WID-1:0]       rd_row,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                       state, state_n;
    logic [A_WID-1:0]             base_q, z_q, row_q, addr_q;
    logic [N_OFF-1:0][A_WID-1:0]  off_q;
    logic [N_OFF-1:0]             en_q;
    logic [I_WID-1:0]             idx_q;

    logic [N_OFF-1:0][A_WID-1:0]  in_off;
    logic [I_WID-1:0]             start_idx, nxt_idx;
    logic [A_WID-1:0]             nxt_row;
    logic                         has_next, hs, last, load, empty;

    assign in_off = addr_offset;

    // Lowest set bit of an enable mask (0 when the mask is empty).
    function automatic logic [I_WID-1:0] low_slot(input logic [N_OFF-1:0] m);
        logic [I_WID-1:0] r;
        r = '0;
        for (int k = N_OFF-1; k >= 0; k--)
            if (m[k]) r = I_WID'(k);
        return r;
    endfunction

    // base + ((o + r) mod z); o and r are both < z, so one conditional
    // subtract in A_WID+1 bits is enough. Base overflow wraps.
    function automatic logic [A_WID-1:0] calc_addr(input logic [A_WID-1:0] b,
                                                   input logic [A_WID-1:0] o,
                                                   input logic [A_WID-1:0] r,
                                                   input logic [A_WID-1:0] z);
        logic [A_WID:0] s;
        s = {1'b0, o} + {1'b0, r};
        if (s >= {1'b0, z}) s = s - {1'b0, z};
        return b + s[A_WID-1:0];
    endfunction

    // Next enabled slot above the current one, else wrap to the next row.
    always_comb begin
        has_next = 1'b0;
        nxt_idx  = low_slot(en_q);
        for (int k = N_OFF-1; k >= 0; k--) begin
            if (en_q[k] && (k > int'(idx_q))) begin
                has_next = 1'b1;
                nxt_idx  = I_WID'(k);
            end
        end
        nxt_row = has_next ? row_q : row_q + A_WID'(1);
    end

    assign start_idx = low_slot(off_en);
    assign empty     = (off_en == '0) || (z_size == '0);
    assign hs        = (state == RUN) && rd_rdy;
    assign last      = hs && !has_next && (row_q == z_q - A_WID'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic; a start is only honoured from IDLE.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: if (start) begin
                load    = 1'b1;
                state_n = empty ? FIN : RUN;
            end
            RUN:  if (last) state_n = FIN;
            FIN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Sweep context and the registered beat (address/slot/row).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            z_q    <= '0;
            off_q  <= '0;
            en_q   <= '0;
            row_q  <= '0;
            idx_q  <= '0;
            addr_q <= '0;
        end else if (load) begin
            base_q <= base_addr;
            z_q    <= z_size;
            off_q  <= in_off;
            en_q   <= off_en;
            row_q  <= '0;
            idx_q  <= start_idx;
            addr_q <= calc_addr(base_addr, in_off[start_idx], A_WID'(0), z_size);
        end else if (hs && !last) begin
            row_q  <= nxt_row;
            idx_q  <= nxt_idx;
            addr_q <= calc_addr(base_q, off_q[nxt_idx], nxt_row, z_q);
        end
    end

    // Beat fields read as zero whenever no beat is being offered.
    assign rd_vld  = (state == RUN);
    assign busy    = (state == RUN);
    assign done    = (state == FIN);
    assign rd_addr = rd_vld ? addr_q : '0;
    assign rd_idx  = rd_vld ? idx_q  : '0;
    assign rd_row  = rd_vld ? row_q  : '0;

endmodule

// File: tb/tb_ldpc_rd_addr_gen.sv
// Bench for ldpc_rd_addr_gen: a queue model of the expected beat stream,
// checked every cycle on the falling edge, plus literal pins of the model.
module tb_ldpc_rd_addr_gen;

    localparam int A_WID = 8;
    localparam int N_OFF = 3;
    localparam int I_WID = 2;

    logic clk = 1'b0;
    logic reset, start, rd_rdy;
    logic [A_WID-1:0] base_addr, z_size;
    logic [N_OFF*A_WID-1:0] addr_offset;
    logic [N_OFF-1:0] off_en;
    logic [A_WID-1:0] rd_addr, rd_row;
    logic [I_WID-1:0] rd_idx;
    logic rd_vld, busy, done;

    ldpc_rd_addr_gen #(.A_WID(A_WID), .N_OFF(N_OFF), .I_WID(I_WID)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .addr_offset(addr_offset), .off_en(off_en), .z_size(z_size),
        .rd_rdy(rd_rdy), .rd_addr(rd_addr), .rd_vld(rd_vld), .rd_idx(rd_idx),
        .rd_row(rd_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int idx; int row; } beat_t;
    beat_t exp_q[$];

    int compared = 0, mismatched = 0;
    bit chk_on = 0;
    int cyc = 0, beats_seen = 0, done_cnt = 0, busy_cnt = 0;
    int hs_cyc = -1, done_cyc = -1, first_vld_cyc = -1, start_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Expected stream straight from the definition: rows outer, slots inner.
    function automatic void build(input int b, input logic [N_OFF*A_WID-1:0] offs,
                                  input logic [N_OFF-1:0] en, input int z);
        exp_q.delete();
        for (int r = 0; r < z; r++)
            for (int k = 0; k < N_OFF; k++)
                if (en[k]) begin
                    beat_t e;
                    e.addr = (b + ((int'(offs[k*A_WID +: A_WID]) + r) % z)) % 256;
                    e.idx  = k;
                    e.row  = r;
                    exp_q.push_back(e);
                end
    endfunction

    // Per-cycle compare against the head of the expected stream.
    always @(negedge clk) begin
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
        if (chk_on) begin
            if (rd_vld) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    chk("rd_addr", int'(rd_addr), exp_q[0].addr);
                    chk("rd_idx", int'(rd_idx), exp_q[0].idx);
                    chk("rd_row", int'(rd_row), exp_q[0].row);
                    if (rd_rdy) begin
                        void'(exp_q.pop_front());
                        beats_seen++;
                        hs_cyc = cyc;
                    end
                end
            end else begin
                chk("idle_idx", int'(rd_idx), 0);
                chk("idle_row", int'(rd_row), 0);
            end
        end
    end

    // mode 0: rd_rdy high; 1: rd_rdy 1,0,0 repeating; 2: rd_rdy high plus stray starts.
    task automatic run_sweep(input int b, input logic [N_OFF*A_WID-1:0] offs,
                             input logic [N_OFF-1:0] en, input int z, input int mode);
        int n, exp_n;
        build(b, offs, en, z);
        exp_n = exp_q.size();
        beats_seen = 0; done_cnt = 0; busy_cnt = 0;
        first_vld_cyc = -1; hs_cyc = -1; done_cyc = -1;
        @(posedge clk); #1;
        base_addr = A_WID'(b); addr_offset = offs; off_en = en; z_size = A_WID'(z);
        rd_rdy = 1'b1; start = 1'b1; start_cyc = cyc; chk_on = 1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 8'hA5; addr_offset = 24'h5A5A5A; off_en = ~en; z_size = 8'h07;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            rd_rdy = (mode == 1) ? (n % 3 == 0) : 1'b1;
            start  = (mode == 2) && (n % 3 == 1);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("timeout", int'(n < 300), 1);
        repeat (2) @(posedge clk);
        #1;
        chk_on = 0;
        chk("beats_left", exp_q.size(), 0);
        chk("beat_count", beats_seen, exp_n);
        chk("done_pulses", done_cnt, 1);
        if (exp_n == 0) chk("done_lat_empty", done_cyc, start_cyc + 1);
        else begin
            chk("first_vld_lat", first_vld_cyc, start_cyc + 1);
            chk("done_lat", done_cyc, hs_cyc + 1);
        end
        if (mode == 0) chk("busy_cycles", busy_cnt, exp_n);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_vld"}, int'(rd_vld), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_addr"}, int'(rd_addr), 0);
        chk({tag, "_idx"}, int'(rd_idx), 0);
        chk({tag, "_row"}, int'(rd_row), 0);
    endtask

    int lit1[12] = '{'h11, 'h13, 'h10, 'h12, 'h10, 'h11, 'h13, 'h11, 'h12, 'h10, 'h12, 'h13};
    int lit2[8]  = '{'h11, 'h10, 'h12, 'h11, 'h13, 'h12, 'h10, 'h13};
    int lit3[4]  = '{'h01, 'hFE, 'hFF, 'h00};

    localparam logic [N_OFF*A_WID-1:0] OFFS1 = 24'h000301;  // slots {0:1, 1:3, 2:0}

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; rd_rdy = 1'b0;
        base_addr = '0; addr_offset = '0; off_en = '0; z_size = '0;
        #3;
        chk_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Pin the model against hand-derived sequences.
        build('h10, OFFS1, 3'b111, 4);
        for (int i = 0; i < 12; i++) chk("model_s1", exp_q[i].addr, lit1[i]);
        build('h10, OFFS1, 3'b101, 4);
        for (int i = 0; i < 8; i++) chk("model_s2", exp_q[i].addr, lit2[i]);
        build('hFE, 24'h000003, 3'b001, 4);
        for (int i = 0; i < 4; i++) chk("model_wrap", exp_q[i].addr, lit3[i]);

        run_sweep('h10, OFFS1, 3'b111, 4, 0);   // full sweep, no stalls
        run_sweep('h10, OFFS1, 3'b101, 4, 0);   // null circulant in slot 1
        run_sweep('h10, OFFS1, 3'b111, 4, 1);   // stalls
        run_sweep('h10, OFFS1, 3'b000, 4, 0);   // no enabled slots
        run_sweep('h10, OFFS1, 3'b111, 0, 0);   // Z = 0
        run_sweep('hFE, 24'h000003, 3'b001, 4, 0);  // modulo and base wrap

        // Reset after beat 5 aborts the sweep without a done pulse.
        build('h10, OFFS1, 3'b111, 4);
        beats_seen = 0;
        @(posedge clk); #1;
        base_addr = 8'h10; addr_offset = OFFS1; off_en = 3'b111; z_size = 8'd4;
        rd_rdy = 1'b1; start = 1'b1; chk_on = 1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (beats_seen < 5 && n < 50) begin @(negedge clk); n++; end
        chk("reset_wait_timeout", int'(n < 50), 1);
        @(posedge clk); #2;
        chk_on = 0; done_cnt = 0;
        reset = 1'b1;
        #1;
        chk_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_cnt, 0);
        chk("idle_after_reset_vld", int'(rd_vld), 0);

        // Fresh sweep from row 0 slot 0 with stray starts during RUN.
        run_sweep('h10, OFFS1, 3'b111, 4, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ldpc_rd_addr_gen.md
Name: ldpc_rd_addr_gen

Overview:
- Parametrised read-address sequencer for the LDPC decoder message memories.
- For one base-matrix row it walks every circulant row 0..Z-1.
- Within each circulant row it emits one read address per enabled non-null offset: base_addr + ((offset + row) mod Z).
- Sits between the layer scheduler (start/base/offsets) and the check-node memory read port, with a valid/ready output handshake.

Parameters:
- A_WID, 8, width of base address, offsets, Z and read address.
- N_OFF, 3, number of offset slots per base-matrix row.
- I_WID, 2, width of rd_idx; must satisfy 2**I_WID >= N_OFF.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle request to begin a sweep; ignored while busy.
- base_addr  input  A_WID  base address of the block row; sampled on accepted start.
- addr_offset  input  N_OFF*A_WID  packed offsets, slot k = bits [(k+1)*A_WID-1 : k*A_WID]; sampled on start.
- off_en  input  N_OFF  slot enable mask (0 = null circulant, skipped); sampled on start.
- z_size  input  A_WID  circulant size Z; sampled on start.
- rd_rdy  input  1  downstream accepts rd_addr this cycle.
- rd_addr  output  A_WID  read address.
- rd_vld  output  1  rd_addr/rd_idx/rd_row valid.
- rd_idx  output  I_WID  slot index of the current address.
- rd_row  output  A_WID  current circulant row.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep end.

Behaviour:
- Reset (asynchronous): all outputs 0, FSM in IDLE, latched registers 0. Reset mid-sweep aborts the sweep; no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE + start:
  - Latch base_addr, addr_offset, off_en and z_size; set row=0 and idx=lowest enabled slot.
  - If off_en==0 or z_size==0, go to FIN; no beats are issued.
  - Otherwise go to RUN.
- RUN: rd_vld=1 and busy=1. Outputs are registered and hold stable while rd_rdy=0.
- Beat: a handshake occurs when rd_vld & rd_rdy. On a handshake, advance to the next enabled slot above idx.
  - If there is none, row++ and idx=lowest enabled slot.
  - If row==Z-1 and idx was the highest enabled slot, go to FIN and drop rd_vld.
- FIN: exactly one cycle with done=1, busy=0, rd_vld=0; then return to IDLE.
- Latency:
  - start in cycle t: first rd_vld in cycle t+1.
  - Final handshake in cycle t: done in cycle t+1.
  - With rd_rdy held high, one beat per cycle, no bubbles. A full sweep takes popcount(off_en)*Z beats.
- Address arithmetic:
  - s = offset_k + row, computed in A_WID+1 bits.
  - If s >= Z, then s = s - Z.
  - rd_addr = (base_addr + s) mod 2**A_WID; base overflow wraps silently.
- Offsets >= Z are illegal; behaviour is unspecified and the bench does not drive them.
- start during RUN or FIN is ignored. Input changes after start have no effect on the sweep.
- rd_idx and rd_row are 0 whenever rd_vld=0.

Test Plan:
- A_WID=8, N_OFF=3, base=0x10, offsets {1,3,0}, off_en=3'b111, Z=4, rd_rdy=1:
  - 12 beats: 11,13,10 / 12,10,11 / 13,11,12 / 10,12,13 (hex).
  - done one cycle after beat 12; busy high for exactly 12 cycles.
- Same setup, off_en=3'b101: 8 beats 11,10 / 12,11 / 13,12 / 10,13; rd_idx only ever 0 or 2.
- Same setup, rd_rdy toggling 1,0,0,1...: rd_addr/rd_idx/rd_row remain stable through stalls; the beat sequence is identical to the first scenario.
- off_en=0 or Z=0: start gives done in cycle t+1; rd_vld never rises.
- base=0xFE, offset 3, Z=4, single slot: addresses 01,FE,FF,00 (wrap in both the modulo and the base add).
- reset asserted after beat 5 of the first scenario:
  - All outputs go to 0 immediately; no done pulse.
  - A new start after release restarts from row 0, slot 0 (address 0x11).
  - start pulses during RUN are ignored.
